// File: rtl/in128_out1536_pack.sv
// rtl/in128_out1536_pack.sv - packs 12 x 128-bit stream beats into one 1536-bit word with per-lane tlast
module in128_out1536_pack #(
  parameter int PAD_ON_LAST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [1535:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [11:0]   m_axis_tlast,
  output logic [3:0]    beat_cnt,
  output logic          pack_busy
);

  localparam int DW    = 128;
  localparam int LANES = 12;
  localparam bit PAD   = (PAD_ON_LAST != 0);

  logic [3:0]          cnt;
  logic [LANES*DW-1:0] acc_data;
  logic [LANES-1:0]    acc_last;
  logic [LANES*DW-1:0] merged_data;
  logic [LANES-1:0]    beat_last;
  logic                accept;
  logic                complete;

  // Input is only taken when the output register is free or draining this cycle.
  assign s_axis_tready = rst_n & (~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = (cnt == 4'd11) | (PAD & s_axis_tlast);
  assign beat_cnt      = cnt;
  assign pack_busy     = (cnt != 4'd0);

  // Accumulator with the current beat dropped into lane cnt; upper lanes stay zero since the
  // accumulator is cleared on every completion.
  always_comb begin
    merged_data = acc_data;
    beat_last   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cnt == 4'(k)) begin
        merged_data[k*DW +: DW] = s_axis_tdata;
        beat_last[k]            = s_axis_tlast;
      end
    end
  end

  // Beat collection and output register; a completing beat may reload the output on the
  // same edge it drains so words can go back-to-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= 4'd0;
      acc_data      <= '0;
      acc_last      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          m_axis_tdata  <= merged_data;
          m_axis_tlast  <= acc_last | beat_last;
          m_axis_tvalid <= 1'b1;
          acc_data      <= '0;
          acc_last      <= '0;
          cnt           <= 4'd0;
        end else begin
          acc_data <= merged_data;
          acc_last <= acc_last | beat_last;
          cnt      <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_in128_out1536_pack.sv
// tb/tb_in128_out1536_pack.sv - randomized and directed bench for in128_out1536_pack, both padding modes
module tb_in128_out1536_pack;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [127:0]         s_tdata = '0;
  logic                 s_tvalid = 1'b0;
  logic                 s_tlast = 1'b0;
  logic                 m_tready = 1'b1;

  // index 0: PAD_ON_LAST=1, index 1: PAD_ON_LAST=0
  logic [1:0]           s_rdy;
  logic [1:0][1535:0]   m_tdata;
  logic [1:0]           m_tvalid;
  logic [1:0][11:0]     m_tlast;
  logic [1:0][3:0]      beat_cnt;
  logic [1:0]           pack_busy;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: beats held for the word being built, and the presented word
  logic [127:0]         mb [2][12];
  logic                 ml [2][12];
  int                   mn [2];
  logic                 ov [2];
  logic [1535:0]        od [2];
  logic [11:0]          ol [2];
  bit                   started = 0;

  // words seen leaving each DUT
  int                   wcount [2];
  logic [1535:0]        wdata [2];
  logic [11:0]          wlast [2];
  int                   rdy_low0 = 0;

  always #5 clk = ~clk;

  in128_out1536_pack #(.PAD_ON_LAST(1)) dut_pad (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_rdy[0]), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[0]), .beat_cnt(beat_cnt[0]), .pack_busy(pack_busy[0])
  );

  in128_out1536_pack #(.PAD_ON_LAST(0)) dut_nopad (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_rdy[1]), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[1]), .beat_cnt(beat_cnt[1]), .pack_busy(pack_busy[1])
  );

  task automatic chk(input string name, input logic [1535:0] act, input logic [1535:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] pat(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {16{b}};
  endfunction

  // Behavioural model: list of beats per word; a word is emitted when 12 are held or, in
  // pad mode, when a tlast beat arrives.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mn[i] = 0; ov[i] = 1'b0; od[i] = '0; ol[i] = '0;
        started = 1;
      end else begin
        bit rdy;
        rdy = !ov[i] || m_tready;
        if (ov[i] && m_tready) ov[i] = 1'b0;
        if (s_tvalid && rdy) begin
          mb[i][mn[i]] = s_tdata;
          ml[i][mn[i]] = s_tlast;
          mn[i]++;
          if (mn[i] == 12 || (i == 0 && s_tlast)) begin
            od[i] = '0; ol[i] = '0;
            for (int k = 0; k < mn[i]; k++) begin
              od[i][k*128 +: 128] = mb[i][k];
              ol[i][k] = ml[i][k];
            end
            ov[i] = 1'b1;
            mn[i] = 0;
          end
        end
      end
    end
  end

  // Compare every cycle once the model has seen a reset edge; also log delivered words.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("s_tready[%0d]", i), 1536'(s_rdy[i]), 1536'(rst_n && (!ov[i] || m_tready)));
        chk($sformatf("m_tvalid[%0d]", i), 1536'(m_tvalid[i]), 1536'(ov[i]));
        if (ov[i]) begin
          chk($sformatf("m_tdata[%0d]", i), m_tdata[i], od[i]);
          chk($sformatf("m_tlast[%0d]", i), 1536'(m_tlast[i]), 1536'(ol[i]));
        end
        chk($sformatf("beat_cnt[%0d]", i), 1536'(beat_cnt[i]), 1536'(mn[i]));
        chk($sformatf("pack_busy[%0d]", i), 1536'(pack_busy[i]), 1536'(mn[i] != 0));
        if (m_tvalid[i] === 1'b1 && m_tready) begin
          wcount[i]++;
          wdata[i] = m_tdata[i];
          wlast[i] = m_tlast[i];
        end
      end
      if (s_rdy[0] !== 1'b1) rdy_low0++;
    end
  end

  task automatic cyc(input logic v, input logic [127:0] d, input logic l, input logic mr);
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("s_tready_in_reset", 1536'(s_rdy[0]), 1536'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1535:0] exp_w;
    int w0, w1, rl;
    wcount[0] = 0; wcount[1] = 0;

    // reset state
    do_reset(2);
    chk("rst_m_tvalid", 1536'(m_tvalid[0]), 1536'(0));
    chk("rst_m_tdata", m_tdata[0], '0);
    chk("rst_m_tlast", 1536'(m_tlast[0]), 1536'(0));
    chk("rst_beat_cnt", 1536'(beat_cnt[0]), 1536'(0));

    // 12 beats, lane k = {16{8'hk}}
    w0 = wcount[0];
    for (int k = 0; k < 12; k++) cyc(1'b1, pat(k), 1'b0, 1'b1);
    chk("full_valid_next_cycle", 1536'(m_tvalid[0]), 1536'(1));
    chk("full_cnt_back_to_0", 1536'(beat_cnt[0]), 1536'(0));
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) exp_w[k*128 +: 128] = pat(k);
    chk("full_words", 1536'(wcount[0] - w0), 1536'(1));
    chk("full_data", wdata[0], exp_w);
    chk("full_tlast", 1536'(wlast[0]), 1536'(0));

    // pad mode: tlast on beat 4 flushes lanes 0..4
    for (int k = 0; k < 5; k++) cyc(1'b1, pat(8'h20 + k), k == 4, 1'b1);
    exp_w = '0;
    for (int k = 0; k < 5; k++) exp_w[k*128 +: 128] = pat(8'h20 + k);
    chk("pad_valid", 1536'(m_tvalid[0]), 1536'(1));
    chk("pad_data", m_tdata[0], exp_w);
    chk("pad_tlast", 1536'(m_tlast[0]), 1536'(12'h010));
    chk("nopad_cnt5", 1536'(beat_cnt[1]), 1536'(5));
    cyc(1'b1, pat(8'h55), 1'b0, 1'b1);
    chk("pad_next_lane0", 1536'(beat_cnt[0]), 1536'(1));
    do_reset(1);

    // tlast on beat 0 and on beat 11 in pad mode
    cyc(1'b1, pat(8'h31), 1'b1, 1'b1);
    chk("pad_beat0_tlast", 1536'(m_tlast[0]), 1536'(12'h001));
    exp_w = '0; exp_w[127:0] = pat(8'h31);
    chk("pad_beat0_data", m_tdata[0], exp_w);
    do_reset(1);
    for (int k = 0; k < 12; k++) cyc(1'b1, pat(8'h40 + k), k == 11, 1'b1);
    chk("pad_beat11_tlast", 1536'(m_tlast[0]), 1536'(12'h800));
    chk("nopad_beat11_tlast", 1536'(m_tlast[1]), 1536'(12'h800));

    // 36 continuous beats
    cyc(1'b0, '0, 1'b0, 1'b1);
    w0 = wcount[0]; rl = rdy_low0;
    for (int k = 0; k < 36; k++) cyc(1'b1, pat(k + 1), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("stream_words", 1536'(wcount[0] - w0), 1536'(3));
    chk("stream_ready_low", 1536'(rdy_low0 - rl), 1536'(0));

    // backpressure: word pending, downstream stalled for 20 cycles
    for (int k = 0; k < 12; k++) cyc(1'b1, pat(8'h60 + k), 1'b0, k < 11);
    for (int k = 0; k < 12; k++) exp_w[k*128 +: 128] = pat(8'h60 + k);
    repeat (20) cyc(1'b1, pat(8'h77), 1'b0, 1'b0);
    chk("bp_data_stable", m_tdata[0], exp_w);
    chk("bp_no_accept", 1536'(beat_cnt[0]), 1536'(0));
    cyc(1'b1, pat(8'h77), 1'b0, 1'b1);
    chk("bp_release_accept", 1536'(beat_cnt[0]), 1536'(1));

    // reset mid-word discards the partial word
    do_reset(1);
    for (int k = 0; k < 7; k++) cyc(1'b1, pat(8'h90 + k), 1'b0, 1'b1);
    do_reset(1);
    w0 = wcount[0];
    for (int k = 0; k < 12; k++) cyc(1'b1, pat(8'hA0 + k), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) exp_w[k*128 +: 128] = pat(8'hA0 + k);
    chk("rst_mid_words", 1536'(wcount[0] - w0), 1536'(1));
    chk("rst_mid_data", wdata[0], exp_w);

    // no-pad mode: tlast on beats 3 and 9
    w0 = wcount[0]; w1 = wcount[1];
    for (int k = 0; k < 12; k++) cyc(1'b1, pat(8'hC0 + k), k == 3 || k == 9, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("nopad_words", 1536'(wcount[1] - w1), 1536'(1));
    chk("nopad_tlast", 1536'(wlast[1]), 1536'(12'h208));
    chk("pad_split_words", 1536'(wcount[0] - w0), 1536'(2));
    chk("pad_split_tlast", 1536'(wlast[0]), 1536'(12'h020));
    chk("pad_leftover", 1536'(beat_cnt[0]), 1536'(2));

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 99) == 0) do_reset(1);
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
